// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: sequencer state encoding and counter sizing helpers
package fir_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        DRAIN      = 3'd2,
        LOAD       = 3'd3,
        FLUSH      = 3'd4,
        WAIT_FLUSH = 3'd5
    } state_e;

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fir_coeff_shadow.sv
// fir_coeff_shadow: host-visible coefficient set, read by the sequencer during a load
module fir_coeff_shadow import fir_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 8,
    localparam int IW        = idx_w(NUM_TAPS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [NUM_TAPS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_TAPS; i++) mem_q[i] <= '0;
        end else if (we && {1'b0, waddr} < (IW+1)'(NUM_TAPS)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fir_filter_ctrl.sv
// fir_filter_ctrl: loads shadow coefficients into the filter, flushes its delay line
// with hidden zero samples, then streams samples; a commit while running drains first.
module fir_filter_ctrl import fir_ctrl_pkg::*; #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_TAPS     = 8,
    parameter int OUTPUT_WIDTH = 2*DATA_WIDTH+$clog2(NUM_TAPS),
    parameter int MAX_INFLIGHT = 16,
    localparam int IW          = idx_w(NUM_TAPS),
    localparam int FW          = cnt_w(MAX_INFLIGHT),
    localparam int CW          = cnt_w(NUM_TAPS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_wr,
    input  logic [IW-1:0]           cfg_addr,
    input  logic [DATA_WIDTH-1:0]   cfg_data,
    input  logic                    cfg_commit,
    output logic                    cfg_ready,
    input  logic                    s_valid,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_ready,
    output logic                    m_valid,
    output logic [OUTPUT_WIDTH-1:0] m_data,
    output logic                    f_coef_we,
    output logic [IW-1:0]           f_coef_idx,
    output logic [DATA_WIDTH-1:0]   f_coef_data,
    output logic                    f_valid,
    output logic [DATA_WIDTH-1:0]   f_x,
    input  logic [OUTPUT_WIDTH-1:0] f_y,
    input  logic                    f_ovalid,
    output logic                    loaded
);
    state_e                  state_q, state_d;
    logic [IW-1:0]           cnt_q, cnt_d;
    logic [FW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           drop_cnt_q, drop_cnt_d;
    logic                    pending_q, pending_d;
    logic                    loaded_q, loaded_d;
    logic                    m_valid_q, m_valid_d;
    logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
    logic [DATA_WIDTH-1:0]   shadow_rd;
    logic                    last_cnt, load_done, enter_drain;

    fir_coeff_shadow #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_TAPS  (NUM_TAPS)
    ) u_shadow (
        .clk   (clk),
        .resetn(resetn),
        .we    (cfg_wr && cfg_ready),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (cnt_q),
        .rdata (shadow_rd)
    );

    assign last_cnt    = cnt_q == IW'(NUM_TAPS-1);
    assign load_done   = state_q == LOAD && last_cnt;
    assign enter_drain = state_q == RUN && (cfg_commit || pending_q);

    assign cfg_ready   = state_q != LOAD;
    assign s_ready     = state_q == RUN && !pending_q;
    assign f_coef_we   = state_q == LOAD;
    assign f_coef_idx  = f_coef_we ? cnt_q : '0;
    assign f_coef_data = f_coef_we ? shadow_rd : '0;
    assign f_valid     = state_q == FLUSH || (s_valid && s_ready);
    assign f_x         = s_ready ? s_data : '0;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign loaded      = loaded_q;

    // LOAD and FLUSH share one NUM_TAPS-cycle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:       state_d = cfg_commit ? LOAD : IDLE;
            RUN:        state_d = enter_drain ? DRAIN : RUN;
            DRAIN:      state_d = inflight_q == '0 ? LOAD : DRAIN;
            LOAD, FLUSH: begin
                cnt_d = last_cnt ? '0 : cnt_q + IW'(1);
                if (last_cnt) state_d = state_q == LOAD ? FLUSH : WAIT_FLUSH;
            end
            WAIT_FLUSH: state_d = drop_cnt_q == '0 ? RUN : WAIT_FLUSH;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d  = enter_drain ? 1'b0
                   : pending_q | (cfg_commit && state_q != IDLE && state_q != RUN);
        inflight_d = inflight_q + FW'(f_valid) - FW'(f_ovalid);
        drop_cnt_d = load_done ? CW'(NUM_TAPS)
                   : drop_cnt_q - CW'(f_ovalid && drop_cnt_q != '0);
        loaded_d   = loaded_q | load_done;
        m_valid_d  = f_ovalid && drop_cnt_q == '0;
        m_data_d   = f_ovalid ? f_y : m_data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            pending_q  <= 1'b0;
            loaded_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            pending_q  <= pending_d;
            loaded_q   <= loaded_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

    a_inflight_ovf: assert property (@(posedge clk) disable iff (!resetn)
        !(f_valid && !f_ovalid && inflight_q == FW'(MAX_INFLIGHT)));
    a_inflight_udf: assert property (@(posedge clk) disable iff (!resetn)
        !(f_ovalid && !f_valid && inflight_q == '0));
endmodule

// File: tb/tb_fir_filter_ctrl.sv
// tb_fir_filter_ctrl: drives the sequencer against a behavioural FIR stand-in and
// checks it against a sample-history reference model.
module tb_fir_filter_ctrl;
    localparam int DW  = 16;
    localparam int NT  = 8;
    localparam int OW  = 2*DW+$clog2(NT);
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_commit = 1'b0;
    logic          cfg_ready;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [OW-1:0] m_data;
    logic          f_coef_we;
    logic [2:0]    f_coef_idx;
    logic [DW-1:0] f_coef_data;
    logic          f_valid;
    logic [DW-1:0] f_x;
    logic [OW-1:0] f_y;
    logic          f_ovalid;
    logic          loaded;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fir_filter_ctrl dut (
        .clk(clk), .resetn(resetn),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_ready(cfg_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data),
        .f_coef_we(f_coef_we), .f_coef_idx(f_coef_idx), .f_coef_data(f_coef_data),
        .f_valid(f_valid), .f_x(f_x), .f_y(f_y), .f_ovalid(f_ovalid),
        .loaded(loaded)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] conv(input logic [DW-1:0] c [NT], input logic [DW-1:0] x [NT]);
        logic signed [OW-1:0] acc = '0;
        for (int k = 0; k < NT; k++) acc = acc + OW'(signed'(c[k])) * OW'(signed'(x[k]));
        return acc;
    endfunction

    // behavioural filter: newest sample in dl[0], fixed LAT-cycle output pipeline
    logic [DW-1:0] fc [NT];
    logic [DW-1:0] dl [NT];
    logic [DW-1:0] nl [NT];
    logic [OW-1:0] py [LAT];
    logic          pv [LAT];
    assign f_y      = py[LAT-1];
    assign f_ovalid = pv[LAT-1];

    always_comb begin
        nl[0] = f_x;
        for (int i = 1; i < NT; i++) nl[i] = dl[i-1];
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                py[i] <= '0;
            end
            for (int i = 0; i < NT; i++) dl[i] <= DW'($urandom);
        end else begin
            if (f_coef_we) fc[f_coef_idx] <= f_coef_data;
            if (f_valid) dl <= nl;
            pv[0] <= f_valid;
            py[0] <= conv(fc, nl);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    // reference model: shadow set, active set, accepted-sample history, expected outputs
    logic [DW-1:0] shadow_m [NT];
    logic [DW-1:0] act_m [NT];
    logic [DW-1:0] hist [NT];
    logic [OW-1:0] exp_q [$];
    int  load_pos = 0, flush_left = 0, drop_left = 0;
    int  loads = 0, emitted = 0, accepted = 0, we_cycles = 0;
    bit  m_exp = 1'b0;
    bit  no_accept = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            for (int i = 0; i < NT; i++) begin
                shadow_m[i] = '0;
                hist[i] = '0;
            end
            exp_q.delete();
            load_pos = 0; flush_left = 0; drop_left = 0; m_exp = 1'b0;
        end else begin
            check("cfg_ready", cfg_ready, !f_coef_we);
            check("m_valid", m_valid, m_exp);
            if (m_valid) begin
                emitted++;
                check("m_extra", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("m_data", m_data, exp_q.pop_front());
            end
            m_exp = f_ovalid && drop_left == 0;
            if (f_ovalid && drop_left > 0) drop_left--;
            if (flush_left > 0) begin
                check("flush_valid", f_valid, 1);
                check("flush_x", f_x, 0);
                flush_left--;
            end else begin
                check("f_valid", f_valid, s_valid && s_ready);
                if (s_valid && s_ready) begin
                    check("f_x", f_x, s_data);
                    for (int i = NT-1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = s_data;
                    exp_q.push_back(conv(act_m, hist));
                    accepted++;
                end
            end
            if (no_accept) check("s_ready_hold", s_ready, 0);
            if (f_coef_we) begin
                we_cycles++;
                check("coef_idx", f_coef_idx, load_pos);
                check("coef_data", f_coef_data, shadow_m[load_pos]);
                act_m[load_pos] = shadow_m[load_pos];
                load_pos++;
                if (load_pos == NT) begin
                    load_pos = 0; loads++; flush_left = NT; drop_left = NT;
                    for (int i = 0; i < NT; i++) hist[i] = '0;
                end
            end else if (load_pos != 0) begin
                check("load_len", load_pos, NT);
                load_pos = 0;
            end
            if (cfg_wr && !f_coef_we) shadow_m[cfg_addr] = cfg_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input logic [DW-1:0] d);
        cfg_wr = 1'b1; cfg_addr = 3'(a); cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic wait_we(input string tag, input logic lvl);
        int n = 0;
        while (f_coef_we !== lvl && n < 300) begin tick(); n++; end
        check(tag, f_coef_we, lvl);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (!s_ready && n < 300) begin tick(); n++; end
        check(tag, s_ready, 1);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        s_valid = 1'b1; s_data = d;
        while (!s_ready && n < 300) begin tick(); n++; end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain_out(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        repeat (4) tick();
        check(tag, exp_q.size(), 0);
    endtask

    task automatic impulse(input string tag);
        int e0 = emitted;
        send(16'd1);
        repeat (NT-1) send(16'd0);
        drain_out({tag, "_drain"});
        check({tag, "_count"}, emitted - e0, NT);
    endtask

    initial begin
        int l0, e0, a0, w0, n;
        // 1: idle after reset ignores the stream
        repeat (3) tick();
        resetn = 1'b1;
        s_valid = 1'b1; s_data = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c % 3 == 0) begin
                check("idle_s_ready", s_ready, 0);
                check("idle_f_valid", f_valid, 0);
                check("idle_m_valid", m_valid, 0);
                check("idle_loaded", loaded, 0);
            end
        end
        s_valid = 1'b0;
        // 2: coeffs 1..8, last write in the commit cycle
        w0 = we_cycles;
        for (int i = 0; i < NT-1; i++) write_coef(i, DW'(i+1));
        cfg_commit = 1'b1;
        write_coef(NT-1, DW'(NT));
        cfg_commit = 1'b0;
        wait_run("t2_run");
        check("t2_loads", loads, 1);
        check("t2_we_cycles", we_cycles - w0, NT);
        check("t2_loaded", loaded, 1);
        // 3: impulse response equals the coefficient list
        impulse("t3_imp");
        // 4: commit mid-stream
        a0 = accepted; e0 = emitted;
        s_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_data = DW'($urandom);
            cfg_commit = c == 11;
            tick();
        end
        cfg_commit = 1'b0;
        check("t4_s_ready_drop", s_ready, 0);
        s_data = DW'($urandom);
        write_coef(5, DW'($urandom_range(1, 200)));
        s_valid = 1'b0;
        wait_we("t4_reload", 1'b1);
        write_coef(2, 16'hBEEF);
        wait_run("t4_run");
        drain_out("t4_drain");
        check("t4_no_loss", emitted - e0, accepted - a0);
        impulse("t4_imp");
        // 5: commit plus coefficient write during FLUSH
        commit();
        wait_we("t5_load", 1'b1);
        wait_we("t5_flush", 1'b0);
        l0 = loads;
        no_accept = 1'b1;
        cfg_commit = 1'b1;
        write_coef(3, DW'($urandom_range(300, 900)));
        cfg_commit = 1'b0;
        n = 0;
        while (loads < l0 + 1 && n < 300) begin tick(); n++; end
        no_accept = 1'b0;
        check("t5_second_load", loads - l0, 1);
        wait_run("t5_run");
        impulse("t5_imp");
        // 6: reset in the middle of a load
        for (int i = 0; i < NT; i++) write_coef(i, DW'($urandom));
        commit();
        n = 0;
        while (!(f_coef_we && f_coef_idx == 3'd4) && n < 300) begin tick(); n++; end
        check("t6_reach_idx4", f_coef_idx, 4);
        resetn = 1'b0;
        #1;
        check("t6_we", f_coef_we, 0);
        check("t6_idx", f_coef_idx, 0);
        check("t6_cdata", f_coef_data, 0);
        check("t6_f_valid", f_valid, 0);
        check("t6_f_x", f_x, 0);
        check("t6_s_ready", s_ready, 0);
        check("t6_m_valid", m_valid, 0);
        check("t6_m_data", m_data, 0);
        check("t6_loaded", loaded, 0);
        repeat (2) tick();
        resetn = 1'b1;
        for (int i = 0; i < NT; i++) write_coef(i, DW'($urandom_range(0, 65535)));
        l0 = loads;
        commit();
        wait_run("t6_run");
        check("t6_reload", loads - l0, 1);
        check("t6_loaded_again", loaded, 1);
        impulse("t6_imp");
        // 7: random traffic, commits and writes in any state
        a0 = accepted; e0 = emitted;
        for (int c = 0; c < 500; c++) begin
            s_valid    = $urandom_range(0, 3) != 0;
            s_data     = DW'($urandom);
            cfg_commit = $urandom_range(0, 59) == 0;
            cfg_wr     = $urandom_range(0, 4) == 0;
            cfg_addr   = 3'($urandom);
            cfg_data   = DW'($urandom);
            tick();
        end
        s_valid = 1'b0; cfg_commit = 1'b0; cfg_wr = 1'b0;
        wait_run("t7_run");
        drain_out("t7_drain");
        check("t7_no_loss", emitted - e0, accepted - a0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
